pit_counter_channel: RTL and testbench
======================================

# pit_counter_channel

Single 8254-style programmable interval timer counter channel. It consumes the 1 MHz `pit_clk` produced by the PIT clock divider as a count-enable qualifier, and runs entirely in the `clk_50m` domain. It is programmed and read by the 8088 bus decode over an 8-bit port pair, and drives `out`, for example to IRQ0 or the speaker. Supports modes 0, 2 and 3, binary counting only, RW modes LSB/MSB/LSB-then-MSB, and the counter-latch command.

## Interface
- Parameters: none.
- `clk_50m` in 1: system clock. All logic is synchronous to its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pit_clk` in 1: 1 MHz count clock, generated synchronously in the `clk_50m` domain. Used only through edge detection.
- `gate` in 1: count gate, synchronous to `clk_50m`.
- `cs` in 1: channel select from bus decode.
- `a0` in 1: port select. 0 = count data, 1 = control word.
- `wr` in 1: one-cycle write strobe, qualified by `cs`.
- `rd` in 1: one-cycle read strobe, qualified by `cs`. Read side effects occur on the edge where `rd` is high.
- `din` in 8: write data.
- `dout` out 8: read data, combinational from the current state.
- `out` out 1: counter output.

## Operation
- **Tick.** `pit_q` registers `pit_clk`. A tick is defined as `pit_clk & ~pit_q`. All counting happens on tick cycles only.
- **State.** 16-bit count register CR, 16-bit counting element CE, 16-bit output latch OL.
- **Control write** (`a0` = 1), field decode:
  - `din[7:6]` is ignored.
  - `din[5:4]` = RW.
  - `din[3:1]` = mode. Modes 2 and 6 map to mode 2; modes 3 and 7 map to mode 3; all others map to mode 0.
  - `din[0]` is ignored.
- **Control write, RW != 00:**
  - Stores mode and RW.
  - Resets the write/read byte pointers to LSB and clears the latch.
  - Sets null-count, so CE halts.
  - `out` goes low for mode 0 and high for modes 2 and 3.
- **Control write, RW = 00:** latch command. If not already latched, OL <= CE and latched <= 1. Mode, RW and counting are unaffected.
- **Count write** (`a0` = 0):
  - RW = 01: CR = {8'h00, din}.
  - RW = 10: CR = {din, 8'h00}.
  - RW = 11: first write sets the LSB, second write sets the MSB, then the pointer toggles back.
  - Write completes on the final byte and sets the load-pending flag.
  - Mode 0: the first byte of an RW = 11 write drives `out` low and halts CE until the MSB arrives.
- **Load.** On the first tick with load pending, CE <= CR (CR = 0 means 65536) and load pending clears.
  - Mode 0: any new complete write reloads on the next tick.
  - Modes 2 and 3: a new CR written while counting takes effect at the next period reload. The exception is the first load after a control write, which loads on the next tick.
- **Mode 0 (terminal count):**
  - Decrement on each tick with `gate` = 1.
  - `out` goes high on the tick where CE becomes 0 and stays high.
  - CE continues counting and wraps 0 -> FFFF.
- **Mode 2 (rate generator):**
  - Decrement on each tick with `gate` = 1.
  - On the tick where CE becomes 1, `out` goes low.
  - On the next tick, CE <= CR and `out` goes high. Period = N ticks, low for 1.
  - N = 1 behaves as N = 2.
- **Mode 3 (square wave):**
  - High phase lasts ceil(N/2) ticks, low phase floor(N/2) ticks.
  - N = 0 gives 32768/32768. N = 1 behaves as N = 2.
  - CE readback value in mode 3 is not specified.
- **Gate:**
  - Mode 0: `gate` = 0 pauses counting.
  - Modes 2 and 3: `gate` = 0 pauses counting and forces `out` high on the next `clk_50m` edge.
  - Modes 2 and 3: a rising edge of `gate` sets a reload, so CE <= CR on the next tick.
- **Read** (`a0` = 0): the source is OL if latched, otherwise CE.
  - RW = 01 returns the LSB. RW = 10 returns the MSB.
  - RW = 11 returns the LSB, then the MSB, with the pointer toggling on each `rd`.
  - Latched clears after the final byte of the latched value is read.
- **Read** (`a0` = 1) returns 8'h00.

## Timing
- **Reset values:** `out` = 0, `dout` = 8'h00, mode 0, RW = 01, CR = CE = OL = 0, null-count = 1, latched = 0, pointers at LSB, `pit_q` = 0.
- **Reset mid-operation** returns immediately to the above. No tick is generated until `pit_clk` next rises after reset release.
- **Latencies:**
  - Control write -> `out` level: next `clk_50m` edge.
  - Complete count write -> CE load: first tick after the write edge.
  - Mode 0: `out` rises N ticks after the load tick.
- **Simultaneous events:**
  - Write and tick in the same cycle: the write takes effect first, and that tick loads CE.
  - Latch command and tick in the same cycle: OL captures the pre-decrement CE.
- One tick is 50 `clk_50m` cycles. Ticks never occur on consecutive cycles.

## Test plan
- **Mode 0, RW = 01:** control 0x10, count 0x05, `gate` = 1 -> `out` low after the control write; load on tick 1; `out` high on tick 6; `out` remains high through the wrap to FFFF.
- **Mode 2, RW = 11:** control 0x34, count 0x04 then 0x00 -> `out` low for exactly 1 tick in every 4 (200 `clk_50m` cycles); period persists over at least 5 periods.
- **Mode 3:** control 0x36 with N = 5 -> high 3 ticks, low 2 ticks. Repeat with N = 4 -> 2/2. With N = 0 -> 32768/32768.
- **Latch:** mode 2, N = 1000, after 10 ticks write control 0x00 -> reads return 0xDE then 0x03 (990) while CE keeps decrementing; an unlatched read afterwards returns the live value.
- **Gate:** mode 2, N = 10, drop `gate` at CE = 6 -> `out` high and CE holds at 6; raise `gate` -> CE = 10 on the next tick and counting resumes.
- **Reset mid-count:** mode 3 running, pulse `rst_n` low -> all outputs and state take their reset values; no counting occurs until a count write.

Source files
------------

// File: rtl/pit_counter_channel.sv
// pit_counter_channel
// One 8254-style interval timer channel. It supports modes 0, 2 and 3, binary
// counting only, the LSB/MSB/LSB-then-MSB access modes and the counter-latch
// command. All logic runs on clk_50m. The 1 MHz pit_clk is used only as an
// edge-detected count enable.
//
// Ports
//   clk_50m  system clock, rising edge
//   rst_n    asynchronous active-low reset
//   pit_clk  1 MHz count clock, synchronous to clk_50m, edge-detected
//   gate     count gate
//   cs, a0   channel select; a0=0 count data, a0=1 control word
//   wr, rd   one-cycle strobes qualified by cs
//   din      write data
//   dout     read data, combinational from current state
//   out      counter output
//
// Bus protocol: a transfer happens on every clk_50m edge where cs and wr (or
// cs and rd) are high. There is no back-pressure. Read data is valid while the
// strobe is high, and the byte-pointer side effects land on that same edge.
module pit_counter_channel (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       pit_clk,
  input  logic       gate,
  input  logic       cs,
  input  logic       a0,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       out
);

  typedef enum logic [1:0] {MODE0 = 2'b00, MODE2 = 2'b10, MODE3 = 2'b11} mode_e;

  mode_e       mode_q, mode_w, mode_dec;
  logic [1:0]  rw_q, rw_w;
  logic [15:0] cr_q, cr_w, ce_q, ce_n, ol_q, ol_w;
  logic        nc_q, nc_w, nc_n;          // null count: no valid CR in CE yet
  logic        lp_q, lp_w, lp_n;          // complete CR written, not yet loaded
  logic        trig_q, trig_w, trig_n;    // gate rising edge pending reload
  logic        latched_q, latched_w;
  logic        wr_msb_q, wr_msb_w, rd_msb_q, rd_msb_w;
  logic        out_q, out_w, out_n;
  logic        high_q, high_w, high_n;    // mode 3 phase: 1 = high half
  logic        pit_q, arm_q, gate_q, tick;
  logic [15:0] n2, half_hi, half_lo, src;
  logic [16:0] n17;
  logic        unused_din;

  assign unused_din = ^{din[7:6], din[0]};

  // A tick needs pit_clk to be seen low at least once after reset. This stops
  // a spurious tick when reset releases while pit_clk is already high.
  assign tick = pit_clk & ~pit_q & arm_q;

  // CR = 1 behaves as 2. CR = 0 stands for 65536. The mode 3 half periods are
  // ceil(N/2) for the high phase and floor(N/2) for the low phase.
  assign n2      = (cr_w == 16'd1) ? 16'd2 : cr_w;
  assign n17     = (cr_w == 16'd0) ? 17'h10000 : {1'b0, n2};
  assign half_hi = n17[16:1] + {15'd0, n17[0]};
  assign half_lo = n17[16:1];

  always_comb begin
    case (din[3:1])
      3'd2, 3'd6: mode_dec = MODE2;
      3'd3, 3'd7: mode_dec = MODE3;
      default:    mode_dec = MODE0;
    endcase
  end

  // Bus stage: apply this cycle's write/read so that a same-cycle tick sees it.
  always_comb begin
    mode_w    = mode_q;
    rw_w      = rw_q;
    cr_w      = cr_q;
    ol_w      = ol_q;
    nc_w      = nc_q;
    lp_w      = lp_q;
    trig_w    = trig_q;
    latched_w = latched_q;
    wr_msb_w  = wr_msb_q;
    rd_msb_w  = rd_msb_q;
    out_w     = out_q;
    high_w    = high_q;
    if (cs && wr && a0) begin
      if (din[5:4] != 2'b00) begin
        mode_w    = mode_dec;
        rw_w      = din[5:4];
        wr_msb_w  = 1'b0;
        rd_msb_w  = 1'b0;
        latched_w = 1'b0;
        nc_w      = 1'b1;
        lp_w      = 1'b0;
        trig_w    = 1'b0;
        high_w    = 1'b1;
        out_w     = (mode_dec != MODE0);
      end else if (!latched_q) begin
        ol_w      = ce_q;
        latched_w = 1'b1;
      end
    end else if (cs && wr) begin
      case (rw_q)
        2'b01: begin
          cr_w = {8'h00, din};
          lp_w = 1'b1;
        end
        2'b10: begin
          cr_w = {din, 8'h00};
          lp_w = 1'b1;
        end
        default: begin
          if (!wr_msb_q) begin
            cr_w[7:0] = din;
            wr_msb_w  = 1'b1;
            if (mode_q == MODE0) begin
              // Mode 0 halts with out low until the MSB completes the count.
              out_w = 1'b0;
              nc_w  = 1'b1;
              lp_w  = 1'b0;
            end
          end else begin
            cr_w[15:8] = din;
            wr_msb_w   = 1'b0;
            lp_w       = 1'b1;
          end
        end
      endcase
    end
    if (cs && rd && !a0) begin
      if (rw_q == 2'b11) rd_msb_w = ~rd_msb_q;
      if (latched_q && (rw_q != 2'b11 || rd_msb_q)) latched_w = 1'b0;
    end
  end

  // Gate and tick stage.
  always_comb begin
    ce_n   = ce_q;
    nc_n   = nc_w;
    lp_n   = lp_w;
    trig_n = trig_w;
    out_n  = out_w;
    high_n = high_w;
    if (mode_w != MODE0) begin
      if (gate && !gate_q) trig_n = 1'b1;
      if (!gate) out_n = 1'b1;
    end
    if (tick) begin
      if (mode_w == MODE0) begin
        if (lp_n) begin
          ce_n  = cr_w;
          lp_n  = 1'b0;
          nc_n  = 1'b0;
          out_n = 1'b0;
        end else if (!nc_n && gate) begin
          ce_n = ce_q - 16'd1;
          if (ce_q == 16'd1) out_n = 1'b1;
        end
      end else if ((lp_n && nc_n) || (trig_n && !nc_n)) begin
        // Initial load after a control word, or restart after gate rose.
        ce_n   = (mode_w == MODE2) ? n2 : half_hi;
        out_n  = 1'b1;
        high_n = 1'b1;
        lp_n   = 1'b0;
        nc_n   = 1'b0;
        trig_n = 1'b0;
      end else if (!nc_n && gate) begin
        if (mode_w == MODE2) begin
          if (ce_q == 16'd1) begin
            ce_n  = n2;
            out_n = 1'b1;
            lp_n  = 1'b0;
          end else begin
            ce_n = ce_q - 16'd1;
            if (ce_q == 16'd2) out_n = 1'b0;
          end
        end else begin
          if (ce_q != 16'd1) begin
            ce_n = ce_q - 16'd1;
          end else if (high_q) begin
            ce_n   = half_lo;
            out_n  = 1'b0;
            high_n = 1'b0;
          end else begin
            ce_n   = half_hi;
            out_n  = 1'b1;
            high_n = 1'b1;
            lp_n   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE0;
      rw_q      <= 2'b01;
      cr_q      <= 16'd0;
      ce_q      <= 16'd0;
      ol_q      <= 16'd0;
      nc_q      <= 1'b1;
      lp_q      <= 1'b0;
      trig_q    <= 1'b0;
      latched_q <= 1'b0;
      wr_msb_q  <= 1'b0;
      rd_msb_q  <= 1'b0;
      out_q     <= 1'b0;
      high_q    <= 1'b1;
      pit_q     <= 1'b0;
      arm_q     <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      mode_q    <= mode_w;
      rw_q      <= rw_w;
      cr_q      <= cr_w;
      ce_q      <= ce_n;
      ol_q      <= ol_w;
      nc_q      <= nc_n;
      lp_q      <= lp_n;
      trig_q    <= trig_n;
      latched_q <= latched_w;
      wr_msb_q  <= wr_msb_w;
      rd_msb_q  <= rd_msb_w;
      out_q     <= out_n;
      high_q    <= high_n;
      pit_q     <= pit_clk;
      arm_q     <= arm_q | ~pit_clk;
      gate_q    <= gate;
    end
  end

  assign src  = latched_q ? ol_q : ce_q;
  assign dout = a0 ? 8'h00
              : ((rw_q == 2'b10) || (rw_q == 2'b11 && rd_msb_q)) ? src[15:8] : src[7:0];
  assign out  = out_q;

endmodule

// File: tb/tb_pit_counter_channel.sv
// Testbench for pit_counter_channel: drives the bus and pit_clk, and compares
// out and read data against values computed from the channel's behaviour.
module tb_pit_counter_channel;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       pit_clk = 1'b0;
  logic       gate;
  logic       cs;
  logic       a0;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       out;

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int pit_cnt = 0;

  pit_counter_channel dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .pit_clk (pit_clk),
    .gate    (gate),
    .cs      (cs),
    .a0      (a0),
    .wr      (wr),
    .rd      (rd),
    .din     (din),
    .dout    (dout),
    .out     (out)
  );

  // Clock and pit_clk generation: 50 MHz system clock, 1 MHz 50% count clock.
  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    pit_cnt = (pit_cnt == 49) ? 0 : pit_cnt + 1;
    pit_clk = (pit_cnt < 25);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, want summary before it");
    $fatal(1, "time limit");
  end

  // Driver tasks.
  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk_50m);
    cs = 1'b1; wr = 1'b1; a0 = a; din = d;
    @(negedge clk_50m);
    cs = 1'b0; wr = 1'b0; a0 = 1'b0; din = 8'h00;
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] d);
    @(negedge clk_50m);
    cs = 1'b1; rd = 1'b1; a0 = a;
    #1 d = dout;
    @(negedge clk_50m);
    cs = 1'b0; rd = 1'b0; a0 = 1'b0;
  endtask

  // Returns 1 ns after the clk_50m edge on which the DUT sees a tick.
  task automatic wait_tick();
    @(posedge pit_clk);
    @(posedge clk_50m);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    logic [7:0]  v;
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL reset_out got %b want %b", out, e[0]); end
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (dout !== e[7:0]) begin n_err++; $display("FAIL reset_dout got %h want %h", dout, e[7:0]); end
    @(negedge clk_50m);
    rst_n = 1'b1;
    wait_tick();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL reset_out_post got %b want %b", out, e[0]); end
    exp_q.push_back(16'h0000);
    bus_rd(1'b0, v);
    e = exp_q.pop_front(); n_vec++;
    if (v !== e[7:0]) begin n_err++; $display("FAIL reset_ce got %h want %h", v, e[7:0]); end
    exp_q.push_back(16'h0000);
    bus_rd(1'b1, v);
    e = exp_q.pop_front(); n_vec++;
    if (v !== e[7:0]) begin n_err++; $display("FAIL ctrl_port_read got %h want %h", v, e[7:0]); end
  endtask

  task automatic test_mode0();
    logic [15:0] e;
    logic [15:0] ce_m;
    logic [7:0]  v;
    wait_tick();
    bus_wr(1'b1, 8'h10);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL m0_ctrl_out got %b want %b", out, e[0]); end
    bus_wr(1'b0, 8'h05);
    ce_m = 16'd5;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({15'd0, (k >= 6)});
      exp_q.push_back({8'd0, ce_m[7:0]});
      ce_m = ce_m - 16'd1;
      wait_tick();
      e = exp_q.pop_front(); n_vec++;
      if (out !== e[0]) begin n_err++; $display("FAIL m0_out tick %0d got %b want %b", k, out, e[0]); end
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if (v !== e[7:0]) begin n_err++; $display("FAIL m0_ce tick %0d got %h want %h", k, v, e[7:0]); end
    end
  endtask

  task automatic test_mode2();
    logic [15:0] e;
    wait_tick();
    bus_wr(1'b1, 8'h34);
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL m2_ctrl_out got %b want %b", out, e[0]); end
    bus_wr(1'b0, 8'h04);
    bus_wr(1'b0, 8'h00);
    for (int k = 1; k <= 21; k++) begin
      exp_q.push_back({15'd0, (k % 4 != 0)});
      wait_tick();
      e = exp_q.pop_front(); n_vec++;
      if (out !== e[0]) begin n_err++; $display("FAIL m2_n4_out tick %0d got %b want %b", k, out, e[0]); end
    end
    // New count mid-period: current period finishes with N=4, then N=6.
    bus_wr(1'b0, 8'h06);
    bus_wr(1'b0, 8'h00);
    for (int k = 22; k <= 31; k++) begin
      exp_q.push_back({15'd0, !(k == 24 || k == 30)});
      wait_tick();
      e = exp_q.pop_front(); n_vec++;
      if (out !== e[0]) begin n_err++; $display("FAIL m2_reload_out tick %0d got %b want %b", k, out, e[0]); end
    end
    // N=1 runs as N=2.
    bus_wr(1'b1, 8'h34);
    bus_wr(1'b0, 8'h01);
    bus_wr(1'b0, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back({15'd0, (k % 2 != 0)});
      wait_tick();
      e = exp_q.pop_front(); n_vec++;
      if (out !== e[0]) begin n_err++; $display("FAIL m2_n1_out tick %0d got %b want %b", k, out, e[0]); end
    end
  endtask

  task automatic test_mode3();
    logic [15:0] e;
    logic [7:0]  nv;
    logic [7:0]  n_tab [3];
    int          len_tab [3];
    n_tab[0] = 8'd5; n_tab[1] = 8'd4; n_tab[2] = 8'd0;
    len_tab[0] = 10; len_tab[1] = 8; len_tab[2] = 20;
    for (int t = 0; t < 3; t++) begin
      nv = n_tab[t];
      wait_tick();
      bus_wr(1'b1, 8'h36);
      exp_q.push_back(16'h0001);
      e = exp_q.pop_front(); n_vec++;
      if (out !== e[0]) begin n_err++; $display("FAIL m3_ctrl_out n=%0d got %b want %b", nv, out, e[0]); end
      bus_wr(1'b0, nv);
      bus_wr(1'b0, 8'h00);
      for (int k = 1; k <= len_tab[t]; k++) begin
        if (nv == 8'd0)
          exp_q.push_back(16'h0001);
        else
          exp_q.push_back({15'd0, ((k - 1) % int'(nv)) < ((int'(nv) + 1) / 2)});
        wait_tick();
        e = exp_q.pop_front(); n_vec++;
        if (out !== e[0]) begin n_err++; $display("FAIL m3_out n=%0d tick %0d got %b want %b", nv, k, out, e[0]); end
      end
    end
  endtask

  task automatic test_latch();
    logic [15:0] e;
    logic [7:0]  v;
    wait_tick();
    bus_wr(1'b1, 8'h34);
    bus_wr(1'b0, 8'hE8);
    bus_wr(1'b0, 8'h03);
    repeat (11) wait_tick();
    bus_wr(1'b1, 8'h00);        // latch 990
    wait_tick();
    bus_wr(1'b1, 8'h00);        // ignored while latched
    wait_tick();                // live count now 988
    exp_q.push_back(16'h00DE);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h00DC);
    exp_q.push_back(16'h0003);
    for (int i = 0; i < 4; i++) begin
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if (v !== e[7:0]) begin n_err++; $display("FAIL latch_read %0d got %h want %h", i, v, e[7:0]); end
    end
  endtask

  task automatic test_gate();
    logic [15:0] e;
    logic [7:0]  v;
    wait_tick();
    bus_wr(1'b1, 8'h34);
    bus_wr(1'b0, 8'h0A);
    bus_wr(1'b0, 8'h00);
    repeat (5) wait_tick();
    @(negedge clk_50m);
    gate = 1'b0;
    @(posedge clk_50m); #1;
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL gate_low_out got %b want %b", out, e[0]); end
    repeat (3) wait_tick();
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 2; i++) begin
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if (v !== e[7:0]) begin n_err++; $display("FAIL gate_hold_ce byte %0d got %h want %h", i, v, e[7:0]); end
    end
    @(negedge clk_50m);
    gate = 1'b1;
    wait_tick();
    exp_q.push_back(16'h000A);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 2; i++) begin
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if (v !== e[7:0]) begin n_err++; $display("FAIL gate_reload_ce byte %0d got %h want %h", i, v, e[7:0]); end
    end
    repeat (9) wait_tick();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL gate_resume_low got %b want %b", out, e[0]); end
    @(negedge clk_50m);
    gate = 1'b0;
    @(posedge clk_50m); #1;
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL gate_force_high got %b want %b", out, e[0]); end
    @(negedge clk_50m);
    gate = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    logic [7:0]  v;
    wait_tick();
    bus_wr(1'b1, 8'h10);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL b2b_ctrl_out got %b want %b", out, e[0]); end
    // Count write on the tick edge: that tick loads the new value.
    @(posedge pit_clk);
    cs = 1'b1; wr = 1'b1; a0 = 1'b0; din = 8'h07;
    @(negedge clk_50m);
    cs = 1'b0; wr = 1'b0; din = 8'h00;
    exp_q.push_back(16'h0007);
    bus_rd(1'b0, v);
    e = exp_q.pop_front(); n_vec++;
    if (v !== e[7:0]) begin n_err++; $display("FAIL b2b_write_tick got %h want %h", v, e[7:0]); end
    // Latch on the tick edge: captures the value before the decrement.
    @(posedge pit_clk);
    cs = 1'b1; wr = 1'b1; a0 = 1'b1; din = 8'h00;
    @(negedge clk_50m);
    cs = 1'b0; wr = 1'b0; a0 = 1'b0;
    exp_q.push_back(16'h0007);
    exp_q.push_back(16'h0006);
    for (int i = 0; i < 2; i++) begin
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if (v !== e[7:0]) begin n_err++; $display("FAIL b2b_latch_tick %0d got %h want %h", i, v, e[7:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    logic [7:0]  v;
    wait_tick();
    bus_wr(1'b1, 8'h36);
    bus_wr(1'b0, 8'h06);
    bus_wr(1'b0, 8'h00);
    wait_tick();
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_vec++;
    if (out !== e[0]) begin n_err++; $display("FAIL rst_mid_pre_out got %b want %b", out, e[0]); end
    @(negedge clk_50m);
    #3 rst_n = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if ({dout, out} !== e[8:0]) begin n_err++; $display("FAIL rst_mid_async got %h/%b want 00/0", dout, out); end
    @(negedge clk_50m);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(16'h0000);
      wait_tick();
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if ({v, out} !== e[8:0]) begin n_err++; $display("FAIL rst_mid_idle tick %0d got %h/%b want 00/0", k, v, out); end
    end
    bus_wr(1'b0, 8'h03);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({7'd0, 8'(4 - k), (k == 4)});
      wait_tick();
      bus_rd(1'b0, v);
      e = exp_q.pop_front(); n_vec++;
      if ({v, out} !== e[8:0]) begin n_err++; $display("FAIL rst_mid_count tick %0d got %h/%b want %h/%b", k, v, out, e[8:1], e[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    gate  = 1'b1;
    cs    = 1'b0;
    a0    = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk_50m);
    #1;
    test_reset();
    test_mode0();
    test_mode2();
    test_mode3();
    test_latch();
    test_gate();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
